// File: rtl/pipe_div.sv
// Sequential signed divider using radix-2 non-restoring iteration, one quotient bit per clock.
// A start/busy/done handshake; results are held until the next completed division or reset.
module pipe_div #(
  parameter int unsigned R = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [R-1:0] a,
  input  logic [R-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [R-1:0] quot,
  output logic [R-1:0] rem,
  output logic         ovf,
  output logic         dz
);

  localparam int unsigned CW = $clog2(R + 1);
  localparam logic [R-1:0] MaxPos = {1'b0, {(R-1){1'b1}}};
  localparam logic [R-1:0] MinNeg = {1'b1, {(R-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [R:0]    p_q, p_d;          // signed partial remainder
  logic [R-1:0]  q_q, q_d;          // dividend magnitude shifting out, quotient shifting in
  logic [R-1:0]  b_mag_q, b_mag_d;
  logic          a_neg_q, a_neg_d;
  logic          q_neg_q, q_neg_d;
  logic          dz_pend_q, dz_pend_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [R-1:0]  quot_q, quot_d;
  logic [R-1:0]  rem_q, rem_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;

  logic [R-1:0]  a_mag, b_mag;
  logic [R:0]    p_sh, p_step;
  logic [R-1:0]  q_step;
  logic [R-1:0]  rem_mag, quot_signed;

  always_comb begin
    a_mag  = a[R-1] ? -a : a;
    b_mag  = b[R-1] ? -b : b;
    p_sh   = {p_q[R-1:0], q_q[R-1]};
    p_step = p_q[R] ? (p_sh + {1'b0, b_mag_q}) : (p_sh - {1'b0, b_mag_q});
    q_step = {q_q[R-2:0], ~p_step[R]};
    // With b=0 every step keeps P>=0, so P ends equal to |a| and rem=a falls out naturally.
    rem_mag     = p_q[R] ? (p_q[R-1:0] + b_mag_q) : p_q[R-1:0];
    quot_signed = q_neg_q ? -q_q : q_q;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    p_d        = p_q;
    q_d        = q_q;
    b_mag_d    = b_mag_q;
    a_neg_d    = a_neg_q;
    q_neg_d    = q_neg_q;
    dz_pend_d  = dz_pend_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quot_d     = quot_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_neg_d    = a[R-1];
          q_neg_d    = a[R-1] ^ b[R-1];
          p_d        = '0;
          q_d        = a_mag;
          b_mag_d    = b_mag;
          dz_pend_d  = (b == '0);
          ovf_pend_d = (a == MinNeg) && (b == '1);
          count_d    = CW'(R);
          busy_d     = 1'b1;
          state_d    = StCalc;
        end
      end
      StCalc: begin
        p_d     = p_step;
        q_d     = q_step;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = StFix;
      end
      StFix: begin
        if (dz_pend_q) begin
          quot_d = a_neg_q ? MinNeg : MaxPos;
        end else if (ovf_pend_q) begin
          quot_d = MaxPos;
        end else begin
          quot_d = quot_signed;
        end
        rem_d   = a_neg_q ? -rem_mag : rem_mag;
        ovf_d   = ovf_pend_q;
        dz_d    = dz_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      p_q        <= '0;
      q_q        <= '0;
      b_mag_q    <= '0;
      a_neg_q    <= 1'b0;
      q_neg_q    <= 1'b0;
      dz_pend_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      p_q        <= p_d;
      q_q        <= q_d;
      b_mag_q    <= b_mag_d;
      a_neg_q    <= a_neg_d;
      q_neg_q    <= q_neg_d;
      dz_pend_q  <= dz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_pipe_div.sv
// Self-checking bench for pipe_div: directed corner cases plus random operands checked
// against an integer-arithmetic reference model.
module tb_pipe_div;

  localparam int R = 14;
  localparam int Lat = R + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [R-1:0] a, b;
  logic         busy, done;
  logic [R-1:0] quot, rem;
  logic         ovf, dz;

  int n_cmp = 0;
  int n_err = 0;
  int last_ovf = 0;
  int last_dz = 0;

  pipe_div #(.R(R)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .quot (quot),
    .rem  (rem),
    .ovf  (ovf),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer division truncates toward zero and % follows the dividend's sign.
  function automatic void model(input int av, input int bv,
                                output int q, output int r, output int o, output int z);
    o = 0;
    z = 0;
    if (bv == 0) begin
      z = 1;
      q = (av >= 0) ? (2 ** (R - 1)) - 1 : -(2 ** (R - 1));
      r = av;
    end else if (av == -(2 ** (R - 1)) && bv == -1) begin
      o = 1;
      q = (2 ** (R - 1)) - 1;
      r = 0;
    end else begin
      q = av / bv;
      r = av % bv;
    end
  endfunction

  function automatic int sx(input logic [R-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic do_div(input int av, input int bv, input bit scramble);
    int n;
    bit got;
    int eq, er, eo, ez;
    model(av, bv, eq, er, eo, ez);
    @(negedge clk);
    a = av[R-1:0];
    b = bv[R-1:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("ovf_held", int'(ovf), last_ovf);
    check("dz_held", int'(dz), last_dz);
    if (scramble) begin
      a = R'($urandom);
      b = R'($urandom);
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (done) got = 1'b1;
    end
    check("latency", n, Lat);
    check("busy_at_done", int'(busy), 0);
    check("quot", sx(quot), eq);
    check("rem", sx(rem), er);
    check("ovf", int'(ovf), eo);
    check("dz", int'(dz), ez);
    last_ovf = eo;
    last_dz = ez;
    @(posedge clk);
    #1;
    check("done_single", int'(done), 0);
  endtask

  initial begin
    int pulses, first_edge, prev_edge, seen;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quot", sx(quot), 0);
    check("rst_rem", sx(rem), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_dz", int'(dz), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_div(100, 7, 1'b0);
    do_div(-100, 7, 1'b1);
    do_div(100, -7, 1'b1);
    do_div(-100, -7, 1'b1);
    do_div(-8192, -1, 1'b1);
    do_div(-8192, 1, 1'b1);
    do_div(5, 0, 1'b1);
    do_div(-5, 0, 1'b1);
    do_div(0, -37, 1'b1);
    do_div(-3, 11, 1'b1);
    do_div(8191, -8192, 1'b1);
    do_div(-8192, -8192, 1'b1);

    for (int i = 0; i < 60; i++) begin
      int av, bv;
      av = int'($urandom_range(0, 16383)) - 8192;
      if (i % 2 == 0) bv = int'($urandom_range(0, 40)) - 20;
      else bv = int'($urandom_range(0, 16383)) - 8192;
      do_div(av, bv, 1'b1);
    end

    // Held start: back-to-back results every R+2 clocks.
    @(negedge clk);
    a = R'(1000);
    b = R'(3);
    start = 1'b1;
    @(posedge clk);
    pulses = 0;
    first_edge = 0;
    prev_edge = 0;
    for (int e = 1; e <= 80 && pulses < 3; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (pulses == 0) first_edge = e;
        else check("b2b_period", e - prev_edge, R + 2);
        prev_edge = e;
        pulses++;
        check("b2b_quot", sx(quot), 333);
        check("b2b_rem", sx(rem), 1);
      end
    end
    check("b2b_pulses", pulses, 3);
    check("b2b_first", first_edge, Lat);
    start = 1'b0;
    seen = 0;
    for (int e = 0; e < 40 && busy; e++) @(posedge clk);
    #1;
    check("b2b_drain", int'(busy), 0);
    last_ovf = 0;
    last_dz = 0;

    // Leave non-zero outputs so the asynchronous clear is observable.
    do_div(5, 0, 1'b0);
    @(negedge clk);
    a = R'(100);
    b = R'(7);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_quot", sx(quot), 0);
    check("mid_rst_rem", sx(rem), 0);
    check("mid_rst_dz", int'(dz), 0);
    @(negedge clk);
    rst = 1'b0;
    last_ovf = 0;
    last_dz = 0;
    seen = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    do_div(9, 4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
